// File: rtl/sata_dma_pkg.sv
// rtl/sata_dma_pkg.sv - shared states and constants for the SATA DMA burst scheduler
package sata_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dma_state_e;

  localparam int BURST_QW          = 16;
  localparam int BURSTS_PER_SECTOR = 4;
  localparam int CMD_ADDR_W        = 25;

endpackage

// File: rtl/dma_outst_cnt.sv
// rtl/dma_outst_cnt.sv - saturating count of issued-but-not-completed bursts
module dma_outst_cnt #(
  parameter int MAX_OUTST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] cnt,
  output logic       underflow
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != 3'(MAX_OUTST)) begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (dec && !inc) begin
      // a completion with nothing in flight is dropped and flagged
      if (cnt_q == 3'd0) begin
        underflow = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dma_burst_sched.sv
// rtl/dma_burst_sched.sv - splits one DMA transfer into 128-byte AXI-HP bursts gated by buffer credit
module dma_burst_sched
  import sata_dma_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int FIFO_LOG  = 9
) (
  input  logic              hclk,
  input  logic              rst_n,
  input  logic [31:7]       mem_address,
  input  logic [31:0]       sector_cnt,
  input  logic              dma_type,
  input  logic              dma_start,
  output logic              dma_done,
  output logic              busy,
  output logic [31:7]       cmd_addr,
  output logic              cmd_wr,
  output logic              cmd_val,
  input  logic              cmd_ack,
  input  logic              burst_done,
  input  logic [FIFO_LOG:0] to_level,
  input  logic [FIFO_LOG:0] from_space,
  output logic              err
);

  localparam int CMP_W = FIFO_LOG + 5;

  dma_state_e            state_q, state_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [33:0]           bursts_left_q, bursts_left_d;
  logic                  val_q, val_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  ack_acc;
  logic [2:0]            outst;
  logic                  underflow;
  logic [CMP_W-1:0]      need;
  logic [CMP_W-1:0]      level;
  logic                  credit_ok;

  assign ack_acc = cmd_ack && val_q;

  dma_outst_cnt #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst (
    .clk       (hclk),
    .rst_n     (rst_n),
    .inc       (ack_acc),
    .dec       (burst_done),
    .cnt       (outst),
    .underflow (underflow)
  );

  // the next burst needs room for itself on top of everything already in flight
  always_comb begin
    need      = (CMP_W'(outst) + CMP_W'(1)) * CMP_W'(BURST_QW);
    level     = wr_q ? CMP_W'(to_level) : CMP_W'(from_space);
    credit_ok = (level >= need) && (outst < 3'(MAX_OUTST));
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    bursts_left_d = bursts_left_q;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          addr_d        = mem_address;
          wr_d          = !dma_type;
          bursts_left_d = 34'(sector_cnt) * 34'(BURSTS_PER_SECTOR);
          err_d         = 1'b0;
          state_d       = ST_ARM;
        end
      end
      ST_ARM: begin
        if (bursts_left_q == 34'd0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_acc) begin
          addr_d        = addr_q + CMD_ADDR_W'(1);
          bursts_left_d = bursts_left_q - 34'd1;
          state_d       = ST_ARM;
        end
      end
      ST_DRAIN: begin
        if (outst == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dma_start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
    if (underflow) begin
      err_d = 1'b1;
    end

    // outputs are registered copies of the upcoming state
    val_d  = (state_d == ST_ISSUE);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      bursts_left_q <= '0;
      val_q         <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      bursts_left_q <= bursts_left_d;
      val_q         <= val_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign cmd_addr = addr_q;
  assign cmd_wr   = wr_q;
  assign cmd_val  = val_q;
  assign dma_done = done_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: doc/dma_burst_sched.md
# dma_burst_sched

Burst scheduler for the SATA DMA datapath, in the AXI-HP (`hclk`) domain. Takes one programmed transfer (memory address, sector count, direction) and splits it into 128-byte AXI-HP burst commands, one per 16 qwords. Each command is issued only when the corresponding host-side buffer can source or sink the whole burst without stalling. It bounds outstanding bursts, counts completions and pulses `dma_done` when the transfer is fully retired.

## Interface
Parameters:
- `MAX_OUTST`, 4: maximum issued-but-not-completed bursts, 1..7.
- `FIFO_LOG`, 9: log2 of buffer depth in qwords; level ports are `FIFO_LOG+1` bits wide.

Ports:
- `hclk`  in  1  AXI-HP clock; sole clock of the block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mem_address`  in  [31:7]  start address in 128-byte units; sampled on accepted start.
- `sector_cnt`  in  32  number of 512-byte sectors; sampled on accepted start.
- `dma_type`  in  1  direction. 0 = device→memory (write bursts); 1 = memory→device (read bursts). Sampled on accepted start.
- `dma_start`  in  1  single-cycle start strobe.
- `dma_done`  out  1  single-cycle pulse when the transfer is retired.
- `busy`  out  1  high from accepted start until the `dma_done` cycle, inclusive.
- `cmd_addr`  out  [31:7]  burst address.
- `cmd_wr`  out  1  1 = write burst (to memory); 0 = read burst.
- `cmd_val`  out  1  command valid.
- `cmd_ack`  in  1  command accepted.
- `burst_done`  in  1  one pulse per completed burst (write response, or last read beat).
- `to_level`  in  `FIFO_LOG+1`  qwords present in the device→memory buffer.
- `from_space`  in  `FIFO_LOG+1`  free qwords in the memory→device buffer.
- `err`  out  1  sticky protocol error; cleared only by reset or by an accepted start.

## Operation
- State machine states: IDLE, ARM, ISSUE, DRAIN, DONE.
- IDLE:
  - `dma_start` is accepted here only.
  - On acceptance, latch address, direction and `bursts_left = sector_cnt*4` (34 bits), clear `err`, go to ARM.
  - `dma_start` in any other state is ignored and sets `err`.
- ARM:
  - If `bursts_left==0`, go to DRAIN.
  - Else, if `outst < MAX_OUTST` and the credit condition holds, go to ISSUE.
  - Credit condition: `to_level ≥ 16*(outst+1)` for a write; `from_space ≥ 16*(outst+1)` for a read. Comparisons are done at `FIFO_LOG+5` bits, with no truncation.
- ISSUE:
  - `cmd_val=1`; `cmd_addr` and `cmd_wr` are stable until `cmd_ack`.
  - On `cmd_ack`: `cmd_addr` increments by 1 (mod 2^25; wrap is legal and silent), `bursts_left` decrements, `outst` increments, return to ARM.
- DRAIN: wait for `outst==0`, then go to DONE.
- DONE: `dma_done=1` for one cycle, then go to IDLE.
- `outst` counter:
  - +1 on `cmd_ack`, −1 on `burst_done`.
  - Both in the same cycle leave it unchanged.
  - `burst_done` with `outst==0` and no simultaneous ack is ignored and sets `err`.
- `sector_cnt==0`: the sequence is IDLE→ARM→DRAIN→DONE; `dma_done` pulses 3 cycles after start and no command is issued.

## Timing
- Reset values: `cmd_val=0`, `cmd_addr=0`, `cmd_wr=0`, `dma_done=0`, `busy=0`, `err=0`, `outst=0`, state IDLE.
- Reset asserted mid-transfer drops `cmd_val` immediately (asynchronous) and abandons outstanding bursts. The datapath is reset together with this block.
- All outputs are registered.
- Start to first `cmd_val` is 2 cycles when credit is already available: start edge → ARM → ISSUE.
- `cmd_ack` to next `cmd_val` is 2 cycles, so the peak rate is one burst per 2 cycles.
- Last `burst_done` (with `outst`→0) to `dma_done` is 2 cycles.
- `cmd_ack` is only sampled while `cmd_val=1`; an ack with `cmd_val=0` is ignored.

## Structure
- Shared package `sata_dma_pkg` holds:
  - state enum;
  - `BURST_QW=16`;
  - `BURSTS_PER_SECTOR=4`;
  - the `cmd_addr` width constant (25).
- One natural sub-module, `dma_outst_cnt`: the saturating up/down outstanding counter, with `err` detection on underflow.

## Test plan
- Write with `sector_cnt=1`, `mem_address=25'h100`, `to_level=64` constant → exactly 4 commands at addresses 0x100..0x103 with `cmd_wr=1`; `dma_done` pulses 2 cycles after the 4th `burst_done`.
- Read with `sector_cnt=2`, `MAX_OUTST=4`, `from_space=48`, `burst_done` withheld → exactly 3 commands issued, then a stall. One `burst_done` → the 4th command follows, and so on.
- `sector_cnt=0` → no `cmd_val`; `dma_done` 3 cycles after start; `busy` high for exactly 3 cycles.
- `mem_address=25'h1FFFFFF`, `sector_cnt=1` → addresses 0x1FFFFFF, 0x0000000, 0x0000001, 0x0000002.
- `cmd_ack` and `burst_done` in the same cycle → `outst` unchanged. Spurious `burst_done` at `outst=0` → `err=1`, held until the next accepted start.
- `rst_n` low during ISSUE → `cmd_val` drops in the same cycle. After release, a new start completes normally.
